// File: rtl/alu_cmd_serializer.sv
// Serial transmitter for ALU commands: accepts {A, B, op} and shifts out up to eight DATA frames
// followed by a CTL frame carrying the opcode and CRC4, one bit per clock on sin.
module alu_cmd_serializer #(
    parameter int unsigned IFG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  op,
    input  logic [3:0]  data_cnt,
    input  logic        crc_inj,
    output logic        ready,
    output logic        sin,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e      state_q;
    logic [63:0] data_q;
    logic [2:0]  op_q;
    logic [3:0]  crc_q;
    logic [3:0]  cnt_q;
    logic [3:0]  frame_q;
    logic [3:0]  bit_q;
    logic [3:0]  gap_q;
    logic        ctl_q;
    logic        ready_q;
    logic        sin_q;
    logic        busy_q;
    logic        done_q;

    logic [3:0]  cnt_clamp;
    logic [3:0]  crc_calc;
    logic [7:0]  byte_sel;
    logic [7:0]  payload;
    logic [10:0] frame_bits;

    // CRC4, poly x^4+x+1, init 0, message MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = msg[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    always_comb begin
        cnt_clamp = (data_cnt > 4'd8) ? 4'd8 : data_cnt;
        crc_calc  = crc4({B, A, 1'b1, op}) ^ {4{crc_inj}};
        byte_sel  = 8'h00;
        unique case (frame_q[2:0])
            3'd0: byte_sel = data_q[63:56];
            3'd1: byte_sel = data_q[55:48];
            3'd2: byte_sel = data_q[47:40];
            3'd3: byte_sel = data_q[39:32];
            3'd4: byte_sel = data_q[31:24];
            3'd5: byte_sel = data_q[23:16];
            3'd6: byte_sel = data_q[15:8];
            3'd7: byte_sel = data_q[7:0];
            default: byte_sel = 8'h00;
        endcase
        payload    = ctl_q ? {1'b0, op_q, crc_q} : byte_sel;
        frame_bits = {1'b0, ctl_q, payload, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            op_q    <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            ctl_q   <= 1'b0;
            ready_q <= 1'b1;
            sin_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && ready_q) begin
                        data_q  <= {B, A};
                        op_q    <= op;
                        crc_q   <= crc_calc;
                        cnt_q   <= cnt_clamp;
                        frame_q <= '0;
                        ctl_q   <= (cnt_clamp == 4'd0);
                        bit_q   <= '0;
                        sin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    // bit_q is the index of the bit currently on the line.
                    if (bit_q != 4'd10) begin
                        bit_q <= bit_q + 4'd1;
                        sin_q <= frame_bits[4'd9 - bit_q];
                    end else if (ctl_q) begin
                        state_q <= StDone;
                        sin_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        frame_q <= frame_q + 4'd1;
                        ctl_q   <= ((frame_q + 4'd1) == cnt_q);
                        bit_q   <= '0;
                        if (IFG == 0) begin
                            sin_q <= 1'b0;
                        end else begin
                            state_q <= StGap;
                            gap_q   <= '0;
                            sin_q   <= 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (gap_q == 4'(IFG - 1)) begin
                        state_q <= StSend;
                        sin_q   <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready = ready_q;
    assign sin   = sin_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alu_cmd_serializer.sv
// Directed bench for alu_cmd_serializer: captures the serial line per command and checks frames,
// gaps and the busy/done/ready timing against bench-built expectations.
module tb_alu_cmd_serializer;

    localparam int unsigned IFG = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic [3:0]  data_cnt;
    logic        crc_inj;
    logic        ready;
    logic        sin;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic cap_sin   [256];
    logic cap_ready [256];
    logic cap_busy  [256];
    logic cap_done  [256];

    alu_cmd_serializer #(.IFG(IFG)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .A        (A),
        .B        (B),
        .op       (op),
        .data_cnt (data_cnt),
        .crc_inj  (crc_inj),
        .ready    (ready),
        .sin      (sin),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] o);
        logic [67:0] m;
        logic [3:0]  c;
        logic        fb;
        m = {b, a, 1'b1, o};
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = m[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic logic [10:0] get_frame(input int s);
        logic [10:0] f;
        for (int k = 0; k < 11; k++) f[10-k] = cap_sin[s+k];
        return f;
    endfunction

    task automatic start_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                             input logic [3:0] cnt, input logic inj, input string tag);
        @(negedge clk);
        A = a; B = b; op = o; data_cnt = cnt; crc_inj = inj; req = 1'b1;
        chk({tag, " ready_at_req"}, 64'(ready), 64'd1);
        @(posedge clk);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req = 1'b0;
                // Scramble inputs to show they were captured at acceptance.
                A = ~A; B = ~B; op = ~op; crc_inj = ~crc_inj;
            end
            cap_sin[i]   = sin;
            cap_ready[i] = ready;
            cap_busy[i]  = busy;
            cap_done[i]  = done;
        end
    endtask

    task automatic run_check(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                             input logic [3:0] cnt, input logic inj, input string tag);
        int          n;
        int          nf;
        int          len;
        int          gaps;
        int          bz;
        int          rd;
        int          dn;
        logic [3:0]  c;
        logic [63:0] d;
        logic [10:0] exp;
        n    = (cnt > 4'd8) ? 8 : int'(cnt);
        nf   = n + 1;
        len  = nf * 11 + (nf - 1) * int'(IFG);
        c    = ref_crc(b, a, o) ^ {4{inj}};
        d    = {b, a};
        gaps = 0; bz = 0; rd = 0; dn = 0;
        start_cmd(a, b, o, cnt, inj, tag);
        capture(len + 2);
        for (int f = 0; f < nf; f++) begin
            if (f < n) exp = {2'b00, d[63-8*f -: 8], 1'b1};
            else       exp = {2'b01, 1'b0, o, c, 1'b1};
            chk($sformatf("%s frame%0d", tag, f), 64'(get_frame(f * (11 + int'(IFG)))), 64'(exp));
        end
        for (int f = 0; f < nf - 1; f++)
            for (int g = 0; g < int'(IFG); g++)
                gaps += int'(cap_sin[f * (11 + int'(IFG)) + 11 + g]);
        chk({tag, " gap_ones"}, 64'(gaps), 64'((nf - 1) * int'(IFG)));
        for (int i = 0; i < len; i++) begin
            bz += int'(cap_busy[i]);
            rd += int'(cap_ready[i]);
            dn += int'(cap_done[i]);
        end
        chk({tag, " busy_cycles"}, 64'(bz), 64'(len));
        chk({tag, " ready_during"}, 64'(rd), 64'd0);
        chk({tag, " done_early"}, 64'(dn), 64'd0);
        chk({tag, " end_cycle sin/ready/busy/done"},
            64'({cap_sin[len], cap_ready[len], cap_busy[len], cap_done[len]}), 64'(4'b1001));
        chk({tag, " after_done sin/ready/busy/done"},
            64'({cap_sin[len+1], cap_ready[len+1], cap_busy[len+1], cap_done[len+1]}),
            64'(4'b1100));
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; A = '0; B = '0; op = '0; data_cnt = 4'd8; crc_inj = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d sin/ready/busy/done", i),
                64'({sin, ready, busy, done}), 64'(4'b1100));
        end

        // All-zero command, full length.
        run_check(32'h0, 32'h0, 3'b000, 4'd8, 1'b0, "zero");
        chk("zero ctl_hand", 64'(get_frame(96)), 64'(11'b01_00001011_1));
        chk("zero data0_hand", 64'(get_frame(0)), 64'(11'b00_00000000_1));

        // First DATA byte ordering and opcode pass-through.
        run_check(32'h0, 32'hA500_0000, 3'b100, 4'd8, 1'b0, "a5");
        chk("a5 frame0_hand", 64'(get_frame(0)), 64'(11'b00_10100101_1));
        chk("a5 ctl_op", 64'(get_frame(96) >> 5) & 64'h7, 64'(3'b100));

        // CRC injection.
        run_check(32'h0, 32'h0, 3'b000, 4'd8, 1'b1, "inj");
        chk("inj ctl_hand", 64'(get_frame(96)), 64'(11'b01_00000100_1));

        // Frame count variants.
        run_check(32'h9ABC_DEF0, 32'h1234_5678, 3'b011, 4'd3, 1'b0, "cnt3");
        chk("cnt3 frame2_hand", 64'(get_frame(24)), 64'(11'b00_01010110_1));
        run_check(32'h9ABC_DEF0, 32'h1234_5678, 3'b111, 4'd0, 1'b0, "cnt0");
        run_check(32'h9ABC_DEF0, 32'h1234_5678, 3'b101, 4'd12, 1'b0, "cnt12");
        chk("cnt12 frame7_hand", 64'(get_frame(84)), 64'(11'b00_11110000_1));

        // Reset during bit 5 of DATA frame 2, then a fresh command.
        start_cmd(32'h0123_4567, 32'hDEAD_BEEF, 3'b010, 4'd8, 1'b0, "rst");
        capture(30);
        chk("rst frame2_prefix", 64'({cap_sin[24], cap_sin[25], cap_sin[26], cap_sin[27],
                                      cap_sin[28], cap_sin[29]}), 64'(6'b001011));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid sin/ready/busy/done", 64'({sin, ready, busy, done}), 64'(4'b1100));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d sin/ready/busy/done", i),
                64'({sin, ready, busy, done}), 64'(4'b1100));
        end
        run_check(32'h0123_4567, 32'hDEAD_BEEF, 3'b010, 4'd8, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
